step_burst_scheduler: RTL and testbench

//  Shares one step-driven counter FSM between two requesters. Each requester asks
//  for a burst of N advance steps. The block grants the counter round-robin and

---
 rtl/step_burst_scheduler.sv | 147 ++++++++++++++
 tb/tb_step_burst_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_burst_scheduler.sv
// Round-robin scheduler sharing one step-driven counter between two requesters.
// Each grant issues a burst of single-cycle step pulses separated by a programmable gap.
module step_burst_scheduler #(
    parameter int LENW = 8,
    parameter int GAPW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [LENW-1:0] len0,
    input  logic [LENW-1:0] len1,
    input  logic [GAPW-1:0] gap,
    input  logic            abort,
    output logic [1:0]      gnt,
    output logic            step,
    output logic            busy,
    output logic [1:0]      done,
    output logic            aborted,
    output logic [LENW-1:0] steps_left,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_STEP  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            abort_q, abort_d;
    logic [LENW-1:0] left_q, left_d;
    logic [GAPW-1:0] gap_lat_q, gap_lat_d;
    logic [GAPW-1:0] gap_cnt_q, gap_cnt_d;

    logic [1:0]      gnt_q, done_q;
    logic            step_q, busy_q, aborted_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        abort_d   = abort_q;
        left_d    = left_q;
        gap_lat_d = gap_lat_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (req != 2'b00) begin
                    // Contention goes to whoever was not served last.
                    owner_d   = (req == 2'b11) ? ~last_q : req[1];
                    left_d    = owner_d ? len1 : len0;
                    gap_lat_d = gap;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (left_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                // The pulse in this cycle is already on the wire, so it always counts.
                left_d = left_q - 1'b1;
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (left_q == LENW'(1)) begin
                    state_d = S_DONE;
                end else if (gap_lat_q == '0) begin
                    state_d = S_STEP;
                end else begin
                    gap_cnt_d = gap_lat_q;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (gap_cnt_q == GAPW'(1)) begin
                    state_d = S_STEP;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                abort_d = 1'b0;
                left_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            abort_q   <= 1'b0;
            left_q    <= '0;
            gap_lat_q <= '0;
            gap_cnt_q <= '0;
            gnt_q     <= 2'b00;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 2'b00;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            abort_q   <= abort_d;
            left_q    <= left_d;
            gap_lat_q <= gap_lat_d;
            gap_cnt_q <= gap_cnt_d;
            // Outputs are registered from the next state so they line up with state_q.
            gnt_q     <= (state_d == S_IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
            step_q    <= (state_d == S_STEP);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
            aborted_q <= (state_d == S_DONE) && abort_d;
        end
    end

    assign gnt        = gnt_q;
    assign step       = step_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign steps_left = left_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_step_burst_scheduler.sv
// Bench for step_burst_scheduler: a burst-schedule model predicts every cycle's outputs,
// directed scenarios pin the model with literal values, then random traffic follows.
module tb_step_burst_scheduler;

    localparam int LENW = 8;
    localparam int GAPW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [LENW-1:0] len0, len1;
    logic [GAPW-1:0] gap;
    logic            abort;
    logic [1:0]      gnt;
    logic            step;
    logic            busy;
    logic [1:0]      done;
    logic            aborted;
    logic [LENW-1:0] steps_left;
    logic [2:0]      dbg_state;

    step_burst_scheduler #(.LENW(LENW), .GAPW(GAPW)) dut (
        .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1), .gap(gap),
        .abort(abort), .gnt(gnt), .step(step), .busy(busy), .done(done),
        .aborted(aborted), .steps_left(steps_left), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      gnt;
        logic            step;
        logic            busy;
        logic [1:0]      done;
        logic            aborted;
        logic [LENW-1:0] sl;
    } obs_t;

    // One entry per upcoming cycle of the active burst; empty means idle.
    obs_t exp_q[$];
    logic last_m;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic obs_t expected();
        if (exp_q.size() == 0) return '0;
        return exp_q[0];
    endfunction

    task automatic model_edge();
        obs_t cur, r;
        logic own;
        int   l, g;
        if (exp_q.size() == 0) begin
            if (req != 2'b00) begin
                own    = (req == 2'b11) ? ~last_m : req[1];
                last_m = own;
                l      = own ? int'(len1) : int'(len0);
                g      = int'(gap);
                r      = '0;
                r.gnt  = own ? 2'b10 : 2'b01;
                r.busy = 1'b1;
                r.sl   = LENW'(l);
                exp_q.push_back(r);
                for (int i = 0; i < l; i++) begin
                    r.step = 1'b1;
                    r.sl   = LENW'(l - i);
                    exp_q.push_back(r);
                    if (i < l - 1) begin
                        for (int j = 0; j < g; j++) begin
                            r.step = 1'b0;
                            r.sl   = LENW'(l - i - 1);
                            exp_q.push_back(r);
                        end
                    end
                end
                r.step = 1'b0;
                r.sl   = '0;
                r.done = r.gnt;
                exp_q.push_back(r);
            end
        end else begin
            cur = exp_q.pop_front();
            if (abort && cur.done == 2'b00) begin
                exp_q.delete();
                r         = cur;
                r.step    = 1'b0;
                r.aborted = 1'b1;
                r.done    = cur.gnt;
                if (cur.step) r.sl = cur.sl - 1'b1;
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic compare();
        obs_t act, ex;
        act = {gnt, step, busy, done, aborted, steps_left};
        ex  = expected();
        vectors++;
        if (act !== ex) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t: got gnt=%b step=%b busy=%b done=%b aborted=%b sl=%0d, expected gnt=%b step=%b busy=%b done=%b aborted=%b sl=%0d",
                     $time, act.gnt, act.step, act.busy, act.done, act.aborted, act.sl,
                     ex.gnt, ex.step, ex.busy, ex.done, ex.aborted, ex.sl);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] ex);
        vectors++;
        if (act !== ex) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, ex);
        end
    endtask

    task automatic cycle(input logic [1:0] r, input logic [LENW-1:0] l0, input logic [LENW-1:0] l1,
                         input logic [GAPW-1:0] g, input logic a);
        req = r; len0 = l0; len1 = l1; gap = g; abort = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    int         nsteps;
    logic [4:0] pat;
    logic [1:0] order [3];
    int         n;

    initial begin
        rst = 1'b0; req = '0; len0 = '0; len1 = '0; gap = '0; abort = 1'b0;
        last_m = 1'b1;
        #1;
        chk("reset_outs", 32'({gnt, step, busy, done, aborted, steps_left}), 32'h0);
        chk("reset_state", 32'(dbg_state), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back burst of 3 for requester 0.
        cycle(2'b01, 8'd3, 8'd0, 4'd0, 1'b0);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_grant_nostep", 32'(step), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(2'b01, 8'd3, 8'd0, 4'd0, 1'b0);
            chk("t1_step", 32'(step), 32'h1);
            chk("t1_left", 32'(steps_left), 32'(3 - i));
        end
        cycle(2'b01, 8'd3, 8'd0, 4'd0, 1'b0);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_left0", 32'(steps_left), 32'h0);
        cycle(2'b00, 8'd0, 8'd0, 4'd0, 1'b0);
        chk("t1_idle_gnt", 32'(gnt), 32'h0);

        // Burst of 2 with gap 2 for requester 1.
        cycle(2'b10, 8'd0, 8'd2, 4'd2, 1'b0);
        chk("t2_gnt", 32'(gnt), 32'h2);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            cycle(2'b10, 8'd0, 8'd2, 4'd2, 1'b0);
            pat = {pat[3:0], step};
        end
        chk("t2_pattern", 32'(pat), 32'b10010);
        chk("t2_done", 32'(done), 32'h2);
        cycle(2'b00, 8'd0, 8'd0, 4'd0, 1'b0);

        // Zero-length burst.
        nsteps = 0;
        cycle(2'b01, 8'd0, 8'd0, 4'd0, 1'b0);
        nsteps += int'(step);
        cycle(2'b01, 8'd0, 8'd0, 4'd0, 1'b0);
        nsteps += int'(step);
        chk("t4_done", 32'(done), 32'h1);
        cycle(2'b00, 8'd0, 8'd0, 4'd0, 1'b0);
        chk("t4_nosteps", 32'(nsteps), 32'h0);

        // Abort during the first gap.
        nsteps = 0;
        cycle(2'b01, 8'd4, 8'd0, 4'd3, 1'b0);
        cycle(2'b01, 8'd4, 8'd0, 4'd3, 1'b0);
        nsteps += int'(step);
        cycle(2'b01, 8'd4, 8'd0, 4'd3, 1'b0);
        nsteps += int'(step);
        cycle(2'b01, 8'd4, 8'd0, 4'd3, 1'b1);
        nsteps += int'(step);
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_aborted", 32'(aborted), 32'h1);
        chk("t5_left", 32'(steps_left), 32'h3);
        chk("t5_nsteps", 32'(nsteps), 32'h1);
        cycle(2'b00, 8'd0, 8'd0, 4'd0, 1'b0);

        // Asynchronous reset in the middle of a step.
        cycle(2'b01, 8'd5, 8'd0, 4'd0, 1'b0);
        cycle(2'b01, 8'd5, 8'd0, 4'd0, 1'b0);
        chk("t6_in_step", 32'(step), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_drop", 32'({gnt, step, busy}), 32'h0);
        exp_q.delete();
        last_m = 1'b1;
        req = 2'b00;
        @(negedge clk);
        compare();
        rst = 1'b1;

        // Both requesting after reset: alternate 0,1,0.
        n = 0;
        order[0] = 2'b00; order[1] = 2'b00; order[2] = 2'b00;
        for (int i = 0; i < 40 && n < 3; i++) begin
            cycle(2'b11, 8'd1, 8'd1, 4'd0, 1'b0);
            if (done != 2'b00) begin
                order[n] = done;
                n++;
            end
        end
        chk("t3_first", 32'(order[0]), 32'h1);
        chk("t3_second", 32'(order[1]), 32'h2);
        chk("t3_third", 32'(order[2]), 32'h1);
        cycle(2'b00, 8'd0, 8'd0, 4'd0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [LENW-1:0] l0, l1;
            logic [GAPW-1:0] g;
            l0 = ($urandom_range(0, 63) == 0) ? LENW'($urandom_range(20, 255)) : LENW'($urandom_range(0, 6));
            l1 = ($urandom_range(0, 63) == 0) ? LENW'($urandom_range(20, 255)) : LENW'($urandom_range(0, 6));
            g  = ($urandom_range(0, 15) == 0) ? GAPW'($urandom_range(4, 15)) : GAPW'($urandom_range(0, 3));
            cycle(2'($urandom_range(0, 3)), l0, l1, g, ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
